// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite slave in front of a word-addressed SRAM: byte/halfword/word access, programmable wait states, two-cycle ERROR.
// Optional macro AHB_SRAM_WRPROT_EN: user-mode writes to the upper half of the array are rejected with ERROR.
module ahb3lite_sram_slave #(
    parameter int HADDR_SIZE  = 32,
    parameter int HDATA_SIZE  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    output logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP
);
    localparam int         AW        = $clog2(MEM_DEPTH);
    localparam logic [2:0] HSIZE_B16 = 3'b001;
    localparam logic [2:0] HSIZE_B32 = 3'b010;

    if (HDATA_SIZE != 32) begin : g_bad_width
        $error("ahb3lite_sram_slave supports HDATA_SIZE=32 only");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

    state_t          state, state_nxt;
    logic [3:0]      cnt, cnt_nxt;
    logic            dph_vld, dph_vld_nxt;
    logic [AW-1:0]   word_q;
    logic [1:0]      lane_q;
    logic [1:0]      size_q;
    logic            write_q;
    logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];
    logic [HDATA_SIZE-1:0] rd_buf, rd_hold;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'd0:    return 4'b0001 << lane;
            2'd1:    return lane[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [HDATA_SIZE-1:0] merge(input logic [HDATA_SIZE-1:0] old_w,
                                                    input logic [HDATA_SIZE-1:0] new_w,
                                                    input logic [3:0] be);
        logic [HDATA_SIZE-1:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++)
            if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
        return res;
    endfunction

    logic          ready_int, accept, xfer_err, prot_err, complete;
    logic [3:0]    be_q;
    logic [AW-1:0] haddr_word;
    logic          unused_bits;

    assign ready_int  = (state == ST_IDLE) || (state == ST_ERR2);
    assign accept     = HSEL && HREADY && HTRANS[1] && ready_int;
    assign complete   = dph_vld && (state == ST_IDLE);
    assign be_q       = lane_mask(size_q, lane_q);
    assign haddr_word = HADDR[AW+1:2];
    assign unused_bits = ^{HBURST, HPROT, HTRANS[0]};

`ifdef AHB_SRAM_WRPROT_EN
    assign prot_err = HWRITE && !HPROT[1] && (HADDR >= HADDR_SIZE'(MEM_DEPTH * 2));
`else
    assign prot_err = 1'b0;
`endif

    assign xfer_err = (HADDR >= HADDR_SIZE'(MEM_DEPTH * 4))
                   || (HSIZE > HSIZE_B32)
                   || ((HSIZE == HSIZE_B16) && HADDR[0])
                   || ((HSIZE == HSIZE_B32) && (HADDR[1:0] != 2'b00))
                   || prot_err;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        dph_vld_nxt = dph_vld;
        case (state)
            ST_IDLE, ST_ERR2: begin
                state_nxt   = ST_IDLE;
                dph_vld_nxt = 1'b0;
                if (accept) begin
                    if (xfer_err) begin
                        state_nxt = ST_ERR1;
                    end else begin
                        dph_vld_nxt = 1'b1;
                        if (WAIT_STATES > 0) begin
                            state_nxt = ST_WAIT;
                            cnt_nxt   = 4'(WAIT_STATES - 1);
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) state_nxt = ST_IDLE;
                else             cnt_nxt   = cnt - 4'd1;
            end
            ST_ERR1: state_nxt = ST_ERR2;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            dph_vld <= 1'b0;
            rd_hold <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            dph_vld <= dph_vld_nxt;
            if (complete && !write_q) rd_hold <= rd_buf;
        end
    end

    // Address phase capture and SRAM read; a write completing this cycle is forwarded into the read.
    always_ff @(posedge HCLK) begin
        if (accept && !xfer_err) begin
            word_q  <= haddr_word;
            lane_q  <= HADDR[1:0];
            size_q  <= HSIZE[1:0];
            write_q <= HWRITE;
            if (!HWRITE) begin
                if (complete && write_q && (word_q == haddr_word))
                    rd_buf <= merge(mem[haddr_word], HWDATA, be_q);
                else
                    rd_buf <= mem[haddr_word];
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (complete && write_q) begin
            for (int b = 0; b < 4; b++)
                if (be_q[b]) mem[word_q][8*b +: 8] <= HWDATA[8*b +: 8];
        end
    end

    assign HRDATA    = (complete && !write_q) ? rd_buf : rd_hold;
    assign HREADYOUT = ready_int;
    assign HRESP     = (state == ST_ERR1) || (state == ST_ERR2);

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Directed bench: three slave instances with WAIT_STATES 0, 3 and 2, each alone on its own bus.
module tb_ahb3lite_sram_slave;
    localparam logic [1:0] T_IDLE = 2'b00, T_NONSEQ = 2'b10;
    localparam logic [2:0] B8 = 3'b000, B16 = 3'b001, B32 = 3'b010, B64 = 3'b011;
    localparam logic [3:0] P_PRIV = 4'b0011, P_USER = 4'b0001;

    logic        clk, rst_n;
    logic        hsel [3];
    logic [31:0] haddr [3];
    logic [31:0] hwdata [3];
    logic [31:0] hrdata [3];
    logic        hwrite [3];
    logic [2:0]  hsize [3];
    logic [2:0]  hburst [3];
    logic [3:0]  hprot [3];
    logic [1:0]  htrans [3];
    logic        hreadyout [3];
    logic        hresp [3];

    int n_cmp = 0;
    int n_mis = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ahb3lite_sram_slave #(
            .HADDR_SIZE(32), .HDATA_SIZE(32), .MEM_DEPTH(256),
            .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 3 : 2))
        ) u_dut (
            .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[g]), .HADDR(haddr[g]),
            .HWDATA(hwdata[g]), .HRDATA(hrdata[g]), .HWRITE(hwrite[g]),
            .HSIZE(hsize[g]), .HBURST(hburst[g]), .HPROT(hprot[g]),
            .HTRANS(htrans[g]), .HREADY(hreadyout[g]), .HREADYOUT(hreadyout[g]),
            .HRESP(hresp[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic addr_phase(input int d, input logic wr, input logic [31:0] a,
                              input logic [2:0] sz, input logic [3:0] prot);
        @(posedge clk); #1;
        hsel[d] = 1'b1; htrans[d] = T_NONSEQ; haddr[d] = a;
        hwrite[d] = wr; hsize[d] = sz; hprot[d] = prot;
    endtask

    task automatic data_phase(input int d, input logic [31:0] wd, output int waits,
                              output logic r0, output logic resp, output logic [31:0] rd);
        logic done;
        @(posedge clk); #1;
        hsel[d] = 1'b0; htrans[d] = T_IDLE; hwdata[d] = wd;
        waits = 0; done = 1'b0; r0 = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (n == 0) r0 = hresp[d];
            if (hreadyout[d]) done = 1'b1;
            else waits++;
        end
        check_val("timeout", 32'(done), 32'd1);
        resp = hresp[d];
        rd = hrdata[d];
    endtask

    task automatic xfer(input int d, input logic wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [3:0] prot, input logic [31:0] wd, output int waits,
                        output logic r0, output logic resp, output logic [31:0] rd);
        addr_phase(d, wr, a, sz, prot);
        data_phase(d, wd, waits, r0, resp, rd);
    endtask

    task automatic ok_write(input string tag, input int d, input logic [31:0] a, input logic [2:0] sz,
                            input logic [3:0] prot, input logic [31:0] wd, input int exp_waits);
        int w; logic r0, rs; logic [31:0] rd;
        xfer(d, 1'b1, a, sz, prot, wd, w, r0, rs, rd);
        check_val({tag, "_waits"}, 32'(w), 32'(exp_waits));
        check_val({tag, "_resp"}, 32'(rs), 32'd0);
    endtask

    task automatic ok_read(input string tag, input int d, input logic [31:0] a,
                           input logic [31:0] exp, input int exp_waits);
        int w; logic r0, rs; logic [31:0] rd;
        xfer(d, 1'b0, a, B32, P_USER, 32'h0, w, r0, rs, rd);
        check_val({tag, "_waits"}, 32'(w), 32'(exp_waits));
        check_val({tag, "_resp"}, 32'(rs), 32'd0);
        check_val({tag, "_data"}, rd, exp);
    endtask

    task automatic err_xfer(input string tag, input int d, input logic wr, input logic [31:0] a,
                            input logic [2:0] sz, input logic [3:0] prot, input logic [31:0] wd);
        int w; logic r0, rs; logic [31:0] rd;
        xfer(d, wr, a, sz, prot, wd, w, r0, rs, rd);
        check_val({tag, "_c1resp"}, 32'(r0), 32'd1);
        check_val({tag, "_c1wait"}, 32'(w), 32'd1);
        check_val({tag, "_c2resp"}, 32'(rs), 32'd1);
    endtask

    // Write immediately followed by a read of the same word, one transfer per cycle.
    task automatic pipe_wr_rd(input string tag, input logic [31:0] wa, input logic [2:0] wsz,
                              input logic [31:0] wd, input logic [31:0] ra, input logic [31:0] exp);
        addr_phase(0, 1'b1, wa, wsz, P_PRIV);
        @(posedge clk); #1;
        haddr[0] = ra; hwrite[0] = 1'b0; hsize[0] = B32; hwdata[0] = wd;
        @(negedge clk);
        check_val({tag, "_wr_rdy"}, 32'(hreadyout[0]), 32'd1);
        @(posedge clk); #1;
        hsel[0] = 1'b0; htrans[0] = T_IDLE;
        @(negedge clk);
        check_val({tag, "_rd_rdy"}, 32'(hreadyout[0]), 32'd1);
        check_val({tag, "_rd_resp"}, 32'(hresp[0]), 32'd0);
        check_val({tag, "_rd_data"}, hrdata[0], exp);
    endtask

    initial begin
        int w; logic r0, rs; logic [31:0] rd;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            hsel[i] = 1'b0; haddr[i] = '0; hwdata[i] = '0; hwrite[i] = 1'b0;
            hsize[i] = B32; hburst[i] = 3'b000; hprot[i] = P_PRIV; htrans[i] = T_IDLE;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("rst_ready%0d", i), 32'(hreadyout[i]), 32'd1);
            check_val($sformatf("rst_resp%0d", i), 32'(hresp[i]), 32'd0);
            check_val($sformatf("rst_rdata%0d", i), hrdata[i], 32'h0);
        end
        rst_n = 1'b1;

        // zero-wait word write/read
        ok_write("w10", 0, 32'h10, B32, P_PRIV, 32'hDEADBEEF, 0);
        ok_read("r10", 0, 32'h10, 32'hDEADBEEF, 0);

        // sub-word lanes
        ok_write("w40", 0, 32'h40, B32, P_PRIV, 32'h0, 0);
        ok_write("w41b", 0, 32'h41, B8, P_PRIV, 32'h0000AA00, 0);
        ok_write("w42h", 0, 32'h42, B16, P_PRIV, 32'h12340000, 0);
        ok_read("r40", 0, 32'h40, 32'h1234AA00, 0);

        // illegal accesses leave memory untouched
        ok_write("w00", 0, 32'h0, B32, P_PRIV, 32'h11223344, 0);
        err_xfer("e_mis32", 0, 1'b1, 32'h2, B32, P_PRIV, 32'hFFFFFFFF);
        err_xfer("e_range", 0, 1'b0, 32'h400, B32, P_PRIV, 32'h0);
        err_xfer("e_size", 0, 1'b1, 32'h0, B64, P_PRIV, 32'hFFFFFFFF);
        err_xfer("e_mis16", 0, 1'b1, 32'h1, B16, P_PRIV, 32'hFFFFFFFF);
        ok_read("r00", 0, 32'h0, 32'h11223344, 0);

        // read data holds across a following write
        xfer(0, 1'b1, 32'h44, B32, P_PRIV, 32'h99999999, w, r0, rs, rd);
        check_val("hold_data", rd, 32'h11223344);

        // back-to-back forwarding: full word, then a single byte lane
        pipe_wr_rd("b2b32", 32'h8, B32, 32'h55AA55AA, 32'h8, 32'h55AA55AA);
        pipe_wr_rd("b2b8", 32'h9, B8, 32'h00007700, 32'h8, 32'h55AA77AA);

`ifdef AHB_SRAM_WRPROT_EN
        ok_write("wp_priv", 0, 32'h300, B32, P_PRIV, 32'h0BADF00D, 0);
        err_xfer("wp_user", 0, 1'b1, 32'h300, B32, P_USER, 32'hA5A5A5A5);
        ok_read("wp_rd", 0, 32'h300, 32'h0BADF00D, 0);
`else
        ok_write("wp_user", 0, 32'h300, B32, P_USER, 32'hA5A5A5A5, 0);
        ok_read("wp_rd", 0, 32'h300, 32'hA5A5A5A5, 0);
`endif

        // three wait states
        ok_write("ws3_w", 1, 32'h20, B32, P_PRIV, 32'hCAFEF00D, 3);
        ok_read("ws3_r", 1, 32'h20, 32'hCAFEF00D, 3);
        err_xfer("ws3_err", 1, 1'b0, 32'h400, B32, P_PRIV, 32'h0);

        // reset during the wait state of a write discards it
        ok_write("ws2_w", 2, 32'h30, B32, P_PRIV, 32'h01020304, 2);
        addr_phase(2, 1'b1, 32'h30, B32, P_PRIV);
        @(posedge clk); #1;
        hsel[2] = 1'b0; htrans[2] = T_IDLE; hwdata[2] = 32'hFFFFFFFF;
        @(negedge clk);
        check_val("ws2_inwait", 32'(hreadyout[2]), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check_val("rstmid_ready", 32'(hreadyout[2]), 32'd1);
        check_val("rstmid_resp", 32'(hresp[2]), 32'd0);
        check_val("rstmid_rdata", hrdata[2], 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ok_read("ws2_r", 2, 32'h30, 32'h01020304, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end
endmodule

// File: doc/ahb3lite_sram_slave.md
Name: ahb3lite_sram_slave

Overview:
AHB3-Lite slave wrapping a word-addressed on-chip SRAM array, sitting directly downstream of the interconnect/decoder and consuming the HTRANS/HSIZE/HBURST/HPROT/HRESP encodings defined in ahb3lite_pkg.
Supports byte, halfword and word transfers, a programmable number of wait states, and the two-cycle ERROR response for illegal accesses.
Serves as the standard memory endpoint for bus-level regressions.

Parameters:
HADDR_SIZE, 32, address bus width
HDATA_SIZE, 32, data bus width (32 only; a larger value is a elaboration error)
MEM_DEPTH, 256, number of HDATA_SIZE-bit words; the decoded window is MEM_DEPTH*4 bytes from offset 0
WAIT_STATES, 0, HREADYOUT-low cycles inserted per OKAY data phase (0..15)

Ports:
HCLK  in  1  bus clock, all logic on rising edge
HRESETn  in  1  asynchronous active-low reset
HSEL  in  1  slave select from decoder
HADDR  in  HADDR_SIZE  address-phase address
HWDATA  in  HDATA_SIZE  write data, valid in data phase
HRDATA  out  HDATA_SIZE  read data
HWRITE  in  1  HWRITE_OP/HREAD_OP
HSIZE  in  3  transfer size (HSIZE_B8..B1024)
HBURST  in  3  burst type, informational only
HPROT  in  4  protection attributes
HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ
HREADY  in  1  bus-wide ready (previous transfer complete)
HREADYOUT  out  1  this slave's ready
HRESP  out  1  HRESP_OKAY/HRESP_ERROR

Behaviour:
- Reset (HRESETn low, async): HREADYOUT=1, HRESP=OKAY, HRDATA=0, FSM=IDLE, wait counter=0. SRAM contents are not reset.
- Address phase is accepted when HSEL && HREADY && HTRANS is NONSEQ or SEQ. The slave registers HADDR, HWRITE, HSIZE and HPROT.
- HSEL with IDLE or BUSY (or HSEL low) while in IDLE gives a zero-wait OKAY: HREADYOUT=1, HRESP=0, no access.
- Error conditions, checked on the registered address phase:
  - address >= MEM_DEPTH*4
  - HSIZE > HSIZE_B32
  - misalignment: HSIZE_B16 with addr[0]=1, or HSIZE_B32 with addr[1:0]!=0
- FSM states: IDLE, WAIT, ERR1, ERR2.
- IDLE, on accept:
  - error: go to ERR1.
  - WAIT_STATES>0: go to WAIT with counter=WAIT_STATES-1.
  - otherwise: complete in the next cycle (HREADYOUT=1).
- WAIT: HREADYOUT=0, HRESP=0. The counter decrements each cycle; at 0 the next cycle is the completion cycle (HREADYOUT=1, OKAY).
  - Total data phase = WAIT_STATES+1 cycles.
- ERR1: HREADYOUT=0, HRESP=1. Always goes to ERR2.
- ERR2: HREADYOUT=1, HRESP=1. No SRAM access occurs for errored transfers.
  - A new address phase sampled during ERR2 is accepted normally; the master may also drive IDLE.
- Write: HWDATA is sampled in the completion cycle and committed at that edge with byte enables.
  - Lanes are little-endian: B8 lane=addr[1:0]; B16 lanes={addr[1],0}+{0,1}; B32 all lanes.
- Read: the SRAM is read at the end of the address phase. HRDATA is valid in the completion cycle and holds its value until the next read completes.
  - Read data is full-word; the master extracts lanes.
- Pipelining: a new address phase may be accepted in the same cycle as a completion (HREADY=1). Back-to-back transfers with WAIT_STATES=0 sustain 1 transfer/cycle.
- Read-after-write to the same word in consecutive transfers returns the newly written data. Implement bypass/forwarding for the pending write bytes when the read address phase overlaps the write data phase.
- HBURST is ignored: each beat is handled as an independent transfer, and address wrap is the master's responsibility.
- Reset asserted mid-transfer aborts immediately to the reset values. A partially completed write is not committed.

Optional Feature:
AHB_SRAM_WRPROT_EN
- Defined: writes with HPROT[1]=0 (user) to the upper half of the array (addr >= MEM_DEPTH*2) receive the two-cycle ERROR and are not committed. Reads are unaffected.
- Undefined: HPROT is ignored entirely and the check logic is absent.

Test Plan:
- Write B32 0xDEADBEEF to 0x10, then read 0x10, WAIT_STATES=0 → each OKAY with HREADYOUT=1 every cycle; HRDATA=0xDEADBEEF.
- WAIT_STATES=3, read 0x20 → HREADYOUT low for exactly 3 cycles, then high with OKAY and data.
- Write B8 0xAA to 0x41, B16 0x1234 to 0x42, then read B32 at 0x40 (after a prior write of 0 to 0x40) → HRDATA=0x1234AA00.
- Read at address MEM_DEPTH*4, and B32 at 0x02 → each: cycle1 HREADYOUT=0/HRESP=1, cycle2 HREADYOUT=1/HRESP=1; memory unchanged.
- Back-to-back NONSEQ write 0x55AA55AA @0x8 immediately followed by read @0x8, WAIT_STATES=0 → read returns 0x55AA55AA.
- Assert HRESETn low during the WAIT state of a write (WAIT_STATES=2) → HREADYOUT=1, HRESP=0 at once; a subsequent read shows the old data. With AHB_SRAM_WRPROT_EN, a user write to 0x300 (MEM_DEPTH=256) returns ERROR.
